// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the round-robin Wishbone arbiter:
//   - Wishbone CTI codes that end a bus cycle
//   - arbiter FSM state encoding
//   - clog2 helper for sizing pointers and counters
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam logic [2:0] CTI_CLASSIC      = 3'b000;
    localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector. Returns the first requester found
// searching cyclically upward from ptr+1.
//   req   in  NUM_REQ  request vector
//   ptr   in  PTR_W    index of the last owner
//   gnt   out NUM_REQ  one-hot winner (zero when no request)
//   valid out 1        at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    logic [PTR_W:0]     shift;
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] low;

    // Rotate so that ptr+1 lands at bit 0, isolate the lowest set bit, then
    // rotate back. Avoids a per-position priority chain.
    assign shift = {1'b0, ptr} + {{PTR_W{1'b0}}, 1'b1};
    assign rot   = NUM_REQ'({req, req} >> shift);
    assign low   = rot & (-rot);
    assign gnt   = NUM_REQ'((({low, low}) << shift) >> NUM_REQ);
    assign valid = |req;

endmodule

// File: rtl/wb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// wb_arbiter_rr
// Round-robin arbiter connecting NUM_MASTERS Wishbone masters to one slave,
// with a per-transfer watchdog.
//   clk, reset_n                 clock, async active-low reset
//   m_*_i                        packed per-master inputs, master i in slice i
//   m_dat_o                      slave read data, broadcast to all masters
//   m_ack_o/m_err_o/m_rty_o      per-master terminations (owner only)
//   s_*_o                        granted master's signals, zero when idle
//   s_dat_i/s_ack_i/s_err_i/s_rty_i  slave read data and terminations
//   grant_o                      one-hot current grant, zero when idle
//   timeout_o                    one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned ADR_WIDTH      = 32,
    parameter int unsigned DAT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_MASTERS*ADR_WIDTH-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DAT_WIDTH-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DAT_WIDTH/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]             m_we_i,
    input  logic [NUM_MASTERS-1:0]             m_lock_i,
    input  logic [NUM_MASTERS-1:0]             m_cyc_i,
    input  logic [NUM_MASTERS-1:0]             m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]           m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]           m_bte_i,
    output logic [DAT_WIDTH-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]             m_ack_o,
    output logic [NUM_MASTERS-1:0]             m_err_o,
    output logic [NUM_MASTERS-1:0]             m_rty_o,
    output logic [ADR_WIDTH-1:0]               s_adr_o,
    output logic [DAT_WIDTH-1:0]               s_dat_o,
    output logic [DAT_WIDTH/8-1:0]             s_sel_o,
    output logic                               s_we_o,
    output logic [2:0]                         s_cti_o,
    output logic [1:0]                         s_bte_o,
    output logic                               s_lock_o,
    output logic                               s_cyc_o,
    output logic                               s_stb_o,
    input  logic [DAT_WIDTH-1:0]               s_dat_i,
    input  logic                               s_ack_i,
    input  logic                               s_err_i,
    input  logic                               s_rty_i,
    output logic [NUM_MASTERS-1:0]             grant_o,
    output logic                               timeout_o
);

    localparam int unsigned PTR_W = clog2(NUM_MASTERS);
    localparam int unsigned SEL_W = DAT_WIDTH / 8;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : clog2(TIMEOUT_CYCLES + 1);
    // The watchdog fires in the cycle whose increment would reach the limit.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       wd_q, wd_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;

    logic [ADR_WIDTH-1:0]   own_adr;
    logic [DAT_WIDTH-1:0]   own_dat;
    logic [SEL_W-1:0]       own_sel;
    logic [2:0]             own_cti;
    logic [1:0]             own_bte;
    logic                   own_we, own_lock, own_cyc, own_stb;
    logic [PTR_W-1:0]       own_idx;

    logic term;
    logic timeout;
    logic release_bus;

    assign req = m_cyc_i & m_stb_i;

    rr_pick #(
        .NUM_REQ (NUM_MASTERS),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (last_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // AND-OR selection of the owner's signals; all zero while grant is empty.
    always_comb begin
        own_adr  = '0;
        own_dat  = '0;
        own_sel  = '0;
        own_cti  = '0;
        own_bte  = '0;
        own_we   = 1'b0;
        own_lock = 1'b0;
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_idx  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            own_adr  = own_adr | (m_adr_i[i*ADR_WIDTH +: ADR_WIDTH] & {ADR_WIDTH{grant_q[i]}});
            own_dat  = own_dat | (m_dat_i[i*DAT_WIDTH +: DAT_WIDTH] & {DAT_WIDTH{grant_q[i]}});
            own_sel  = own_sel | (m_sel_i[i*SEL_W +: SEL_W] & {SEL_W{grant_q[i]}});
            own_cti  = own_cti | (m_cti_i[i*3 +: 3] & {3{grant_q[i]}});
            own_bte  = own_bte | (m_bte_i[i*2 +: 2] & {2{grant_q[i]}});
            own_we   = own_we   | (m_we_i[i]   & grant_q[i]);
            own_lock = own_lock | (m_lock_i[i] & grant_q[i]);
            own_cyc  = own_cyc  | (m_cyc_i[i]  & grant_q[i]);
            own_stb  = own_stb  | (m_stb_i[i]  & grant_q[i]);
            own_idx  = own_idx  | (PTR_W'(i) & {PTR_W{grant_q[i]}});
        end
    end

    // Watchdog and release decode. A real slave termination masks the timeout.
    always_comb begin
        term        = s_ack_i | s_err_i | s_rty_i;
        timeout     = (TIMEOUT_CYCLES != 0) && (state_q == ST_OWNED) &&
                      own_stb && !term && (wd_q == WD_LAST);
        release_bus = !own_cyc || timeout ||
                      (term && !own_lock &&
                       ((own_cti == CTI_CLASSIC) || (own_cti == CTI_END_OF_BURST)));
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= PTR_W'(NUM_MASTERS - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (pick_valid) begin
                    state_d = ST_OWNED;
                    grant_d = pick_gnt;
                end
            end
            ST_OWNED: begin
                if (release_bus) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = own_idx;
                    wd_d    = '0;
                end else if (term) begin
                    wd_d = '0;
                end else if (own_stb && (wd_q != '1)) begin
                    wd_d = wd_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        s_adr_o   = own_adr;
        s_dat_o   = own_dat;
        s_sel_o   = own_sel;
        s_we_o    = own_we;
        s_cti_o   = own_cti;
        s_bte_o   = own_bte;
        s_lock_o  = own_lock;
        s_cyc_o   = own_cyc & ~timeout;
        s_stb_o   = own_stb & ~timeout;
        m_dat_o   = s_dat_i;
        m_ack_o   = grant_q & {NUM_MASTERS{s_ack_i}};
        m_err_o   = grant_q & {NUM_MASTERS{s_err_i | timeout}};
        m_rty_o   = grant_q & {NUM_MASTERS{s_rty_i}};
        grant_o   = grant_q;
        timeout_o = timeout;
    end

endmodule
